jk_sync_counter: RTL and testbench
==================================

JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 en  input  1  count enable; 0 = hold.
REQ-005 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 load  input  1  synchronous parallel load of din.
REQ-007 din  input  WIDTH  load value.
REQ-008 mod_val  input  WIDTH  terminal (maximum) count; the sequence spans 0..mod_val.
REQ-009 q  output  WIDTH  registered count.
REQ-010 qbar  output  WIDTH  bitwise complement of q, taken from the flop complement outputs.
REQ-011 j_vec  output  WIDTH  J excitation presented to each bit cell this cycle (combinational).
REQ-012 k_vec  output  WIDTH  K excitation presented to each bit cell this cycle (combinational).
REQ-013 tc  output  1  terminal-count flag (combinational).

Function
REQ-014 Each q bit SHALL be held in a JK cell: JK=00 hold, 01 clear, 10 set, 11 toggle.
REQ-015 The block SHALL compute a target next state n, then derive the excitation per bit: J_i = ~q_i & n_i, K_i = q_i & ~n_i (no don't-care toggles).
REQ-016 Priority SHALL be: reset, then load, then en, then hold.
REQ-017 load=1: n = din, regardless of en, up or mod_val; din > mod_val is accepted as loaded.
REQ-018 en=1, up=1: n = 0 if q >= mod_val, else q+1.
REQ-019 en=1, up=0: n = mod_val if q == 0, else q-1; q > mod_val decrements normally.
REQ-020 en=0 and load=0: n = q, so j_vec = k_vec = 0.
REQ-021 q SHALL equal n one cycle after the controlling inputs are sampled; latency is exactly 1 clk.
REQ-022 tc = en & ~load & ((up & q == mod_val) | (~up & q == 0)).
REQ-023 mod_val = 0 SHALL hold q at 0 with tc = 1 whenever en=1 and load=0.
REQ-024 mod_val and direction SHALL be able to change on any cycle; each change takes effect for the next state computed in that same cycle.
REQ-025 All arithmetic SHALL be WIDTH-bit unsigned, with no carry out beyond WIDTH.

Reset
REQ-026 When reset=0 at a rising clk, q SHALL become 0 and qbar all-ones, regardless of load or en.
REQ-027 While reset=0, j_vec and k_vec SHALL be driven to 0.
REQ-028 Asserting reset mid-count SHALL abandon the sequence; counting SHALL resume from 0 on the first edge after release.
REQ-029 Before the first reset, q is unspecified; the bench does not check outputs until after reset.

Structure
REQ-030 A shared package jk_pkg SHALL hold the JK encoding constants JK_HOLD=00, JK_CLR=01, JK_SET=10, JK_TGL=11, and the default WIDTH.
REQ-031 A sub-module jk_cell SHALL implement one JK flip-flop with ports clk, reset (sync, active-low), j, k, q, qbar; jk_sync_counter SHALL instantiate WIDTH copies.
REQ-032 Next-state and excitation logic SHALL reside in jk_sync_counter, not in jk_cell.

Verification (WIDTH=4)
REQ-033 Reset: reset=0 for 2 edges with load=1, din=9 -> q=0, qbar=F, j_vec=k_vec=0.
REQ-034 Up wrap: mod_val=5, up=1, en=1 from 0 for 7 edges -> q = 1,2,3,4,5,0,1; tc=1 only while q=5.
REQ-035 Down wrap: mod_val=9, up=0, en=1 from q=1 -> q = 0,9,8; tc=1 while q=0; at q=0, j_vec=9 and k_vec=0.
REQ-036 Load priority: q=3, en=1, load=1, din=C, mod_val=5 -> q=C next edge; then up count -> q=0.
REQ-037 Hold and excitation: en=0 at q=6 for 3 edges -> q stays 6, j_vec=k_vec=0; en=1, up=1 at q=7 -> j_vec=8, k_vec=7, q=8.
REQ-038 Mid-run reset: counting up at q=4, reset=0 for one edge -> q=0; after release q=1 on the following edge.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and default counter width.
package jk_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // JK input pair encodings, written as {j, k}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset.
// The true and complement outputs are held in two separate flops.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  // JK state update: hold, clear, set or toggle. Reset overrides all of these.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else begin
      case ({j, k})
        JK_HOLD: begin
          q    <= q;
          qbar <= qbar;
        end
        JK_CLR: begin
          q    <= 1'b0;
          qbar <= 1'b1;
        end
        JK_SET: begin
          q    <= 1'b1;
          qbar <= 1'b0;
        end
        default: begin
          q    <= ~q;
          qbar <= ~qbar;
        end
      endcase
    end
  end

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo up/down synchronous counter built from JK cells.
// The wanted next count is computed first. Each bit's J/K excitation is then
// derived from it, so a bit only sets or clears when it must change.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc
);

  logic [WIDTH-1:0] n;

  // Target next state: load beats enable; wrap at 0 and at mod_val.
  always_comb begin
    n = q;
    if (load) begin
      n = din;
    end else if (en) begin
      if (up) begin
        n = (q >= mod_val) ? '0 : q + WIDTH'(1);
      end else begin
        n = (q == '0) ? mod_val : q - WIDTH'(1);
      end
    end
  end

  // Excitation: set only the bits that must rise, clear only the bits that must fall.
  // Both vectors are forced to zero while reset is asserted.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (reset) begin
      j_vec = ~q & n;
      k_vec = q & ~n;
    end
  end

  // Terminal-count flag for the current direction.
  always_comb begin
    tc = en & ~load & ((up & (q == mod_val)) | (~up & (q == '0)));
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (j_vec[gi]),
      .k    (k_vec[gi]),
      .q    (q[gi]),
      .qbar (qbar[gi])
    );
  end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter, WIDTH=4. Expected values are hand-computed.
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic [3:0] mod_val;
  logic [3:0] q;
  logic [3:0] qbar;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       tc;

  int checks = 0;
  int errors = 0;

  jk_sync_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .up     (up),
    .load   (load),
    .din    (din),
    .mod_val(mod_val),
    .q      (q),
    .qbar   (qbar),
    .j_vec  (j_vec),
    .k_vec  (k_vec),
    .tc     (tc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end else begin
      $display("ok   %s value=%0h", tag, actual);
    end
  endtask

  // Advance one rising edge, then step 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Load a value, leaving en, up and mod_val untouched.
  task automatic load_val(input logic [3:0] v);
    load = 1'b1;
    din  = v;
    tick();
    load = 1'b0;
    settle();
  endtask

  logic [3:0] up_seq [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};

  initial begin
    // Reset is held for 2 edges while load is asserted with din=9.
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b1; din = 4'd9; mod_val = 4'd5;
    tick();
    tick();
    check_eq("rst_q", 8'(q), 8'h0);
    check_eq("rst_qbar", 8'(qbar), 8'hF);
    check_eq("rst_j", 8'(j_vec), 8'h0);
    check_eq("rst_k", 8'(k_vec), 8'h0);

    // Up count with mod_val=5, starting from 0.
    reset = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1; mod_val = 4'd5;
    settle();
    check_eq("up_tc_q0", 8'(tc), 8'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("up_q[%0d]", i), 8'(q), 8'(up_seq[i]));
      check_eq($sformatf("up_tc[%0d]", i), 8'(tc), (up_seq[i] == 4'd5) ? 8'h1 : 8'h0);
    end

    // Down count with mod_val=9, starting from q=1.
    up = 1'b0; mod_val = 4'd9;
    settle();
    check_eq("dn_tc_q1", 8'(tc), 8'h0);
    tick();
    check_eq("dn_q0", 8'(q), 8'h0);
    check_eq("dn_tc_q0", 8'(tc), 8'h1);
    check_eq("dn_j_q0", 8'(j_vec), 8'h9);
    check_eq("dn_k_q0", 8'(k_vec), 8'h0);
    tick();
    check_eq("dn_q9", 8'(q), 8'h9);
    check_eq("dn_tc_q9", 8'(tc), 8'h0);
    tick();
    check_eq("dn_q8", 8'(q), 8'h8);

    // Load takes priority over enable. din=C is above mod_val=5.
    load_val(4'd3);
    check_eq("ld_q3", 8'(q), 8'h3);
    en = 1'b1; up = 1'b1; load = 1'b1; din = 4'hC; mod_val = 4'd5;
    settle();
    check_eq("ld_tc", 8'(tc), 8'h0);
    check_eq("ld_j", 8'(j_vec), 8'hC);
    check_eq("ld_k", 8'(k_vec), 8'h3);
    tick();
    check_eq("ld_qC", 8'(q), 8'hC);
    load = 1'b0;
    tick();
    check_eq("ld_wrap0", 8'(q), 8'h0);

    // Hold at q=6, then check excitation on the 7 -> 8 step.
    mod_val = 4'd9;
    load_val(4'd6);
    en = 1'b0;
    settle();
    check_eq("hold_j", 8'(j_vec), 8'h0);
    check_eq("hold_k", 8'(k_vec), 8'h0);
    check_eq("hold_tc", 8'(tc), 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("hold_q[%0d]", i), 8'(q), 8'h6);
    end
    load_val(4'd7);
    en = 1'b1; up = 1'b1;
    settle();
    check_eq("exc_j", 8'(j_vec), 8'h8);
    check_eq("exc_k", 8'(k_vec), 8'h7);
    tick();
    check_eq("exc_q8", 8'(q), 8'h8);

    // mod_val=0 pins q at 0 with tc high.
    mod_val = 4'd0;
    tick();
    check_eq("m0_q_a", 8'(q), 8'h0);
    check_eq("m0_tc_up", 8'(tc), 8'h1);
    tick();
    check_eq("m0_q_b", 8'(q), 8'h0);
    up = 1'b0;
    settle();
    check_eq("m0_tc_dn", 8'(tc), 8'h1);
    tick();
    check_eq("m0_q_c", 8'(q), 8'h0);

    // Reset asserted mid-count abandons the sequence.
    mod_val = 4'd9; up = 1'b1;
    load_val(4'd4);
    reset = 1'b0;
    settle();
    check_eq("mid_rst_j", 8'(j_vec), 8'h0);
    check_eq("mid_rst_k", 8'(k_vec), 8'h0);
    tick();
    check_eq("mid_rst_q", 8'(q), 8'h0);
    check_eq("mid_rst_qbar", 8'(qbar), 8'hF);
    reset = 1'b1;
    tick();
    check_eq("mid_rel_q1", 8'(q), 8'h1);
    check_eq("mid_rel_qbar", 8'(qbar), 8'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
